pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 142 ++++++++++++++
 tb/tb_pc_gen.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen -- fetch program-counter generator.
//
// Produces the fetch address stream for the instruction cache. The PC normally
// steps by 4, or by 2 when the instruction at the current address is
// compressed. Redirect requests replace the PC and bump the epoch tag. A
// redirect that arrives while the front end is stalled or still idle is parked
// in a one-entry pending register and applied later.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - synchronous active-high reset
//   redir_valid_i  - one redirect request per source (index 0 = highest priority)
//   redir_pc_i     - redirect targets, source k in bits [k*XLEN +: XLEN]
//   stall_i        - freeze PC advance and redirect application
//   rvc_i          - instruction at fetch_pc_o is compressed (step 2, not 4)
//   fetch_ready_i  - icache accepts the current request
//   fetch_valid_o  - fetch request valid (high in RUN)
//   fetch_pc_o     - registered fetch address
//   fetch_epoch_o  - epoch tag of fetch_pc_o
//   redir_taken_o  - one-cycle pulse: fetch_pc_o was loaded from a redirect
//   pend_valid_o   - a deferred redirect is held
module pc_gen #(
  parameter int              XLEN       = 64,
  parameter int              NUM_REDIR  = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(64'h8000_0000),
  parameter int              EPOCH_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
  input  logic                      stall_i,
  input  logic                      rvc_i,
  input  logic                      fetch_ready_i,
  output logic                      fetch_valid_o,
  output logic [XLEN-1:0]           fetch_pc_o,
  output logic [EPOCH_W-1:0]        fetch_epoch_o,
  output logic                      redir_taken_o,
  output logic                      pend_valid_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               taken_q, taken_d;
  logic               pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]    pend_pc_q, pend_pc_d;

  logic               new_valid;
  logic [XLEN-1:0]    new_target;
  logic [XLEN-1:0]    new_pc;
  logic               apply;
  logic [XLEN-1:0]    step;

  // Fixed-priority pick of the incoming redirect. Scanning from the top index
  // down lets the lowest valid index overwrite the others and win.
  always_comb begin
    new_valid  = 1'b0;
    new_target = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        new_valid  = 1'b1;
        new_target = redir_pc_i[k*XLEN +: XLEN];
      end
    end
  end

  // Redirect targets are always at least halfword aligned.
  assign new_pc = {new_target[XLEN-1:1], 1'b0};

  assign apply = (state_q == RUN) && !stall_i;
  assign step  = rvc_i ? XLEN'(2) : XLEN'(4);

  // State register plus all architectural state of the generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_ADDR;
      epoch_q      <= '0;
      taken_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epoch_q      <= epoch_d;
      taken_q      <= taken_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // Next-state logic. A fresh redirect beats a pending one, which beats the
  // sequential step; an abort of an unaccepted fetch is allowed because the
  // redirect branches do not look at fetch_ready_i. When a redirect cannot be
  // applied (stall or IDLE) it replaces whatever was pending.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epoch_d      = epoch_q;
    taken_d      = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    fetch_valid_o = (state_q == RUN);

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (apply) begin
      if (new_valid) begin
        pc_d         = new_pc;
        epoch_d      = epoch_q + 1'b1;
        taken_d      = 1'b1;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        pc_d         = pend_pc_q;
        epoch_d      = epoch_q + 1'b1;
        taken_d      = 1'b1;
        pend_valid_d = 1'b0;
      end else if (fetch_ready_i) begin
        pc_d = pc_q + step;
      end
    end else if (new_valid) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = new_pc;
    end
  end

  assign fetch_pc_o    = pc_q;
  assign fetch_epoch_o = epoch_q;
  assign redir_taken_o = taken_q;
  assign pend_valid_o  = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- self-checking bench for pc_gen.
//
// A behavioural model tracks what the fetch address, epoch, pending redirect
// and pulse outputs should be after every rising edge. Directed scenarios
// check the documented sequences against literal values; a randomized phase
// compares every output against the model each cycle.
module tb_pc_gen;

  localparam int XLEN      = 64;
  localparam int NUM_REDIR = 4;
  localparam int EPOCH_W   = 3;

  logic                      clk;
  logic                      rst;
  logic [NUM_REDIR-1:0]      redir_valid_i;
  logic [NUM_REDIR*XLEN-1:0] redir_pc_i;
  logic                      stall_i;
  logic                      rvc_i;
  logic                      fetch_ready_i;
  logic                      fetch_valid_o;
  logic [XLEN-1:0]           fetch_pc_o;
  logic [EPOCH_W-1:0]        fetch_epoch_o;
  logic                      redir_taken_o;
  logic                      pend_valid_o;

  int vectors;
  int miscompares;

  // Reference model state
  bit          m_run;
  logic [63:0] m_pc;
  int          m_epoch;
  bit          m_taken;
  bit          m_pend_v;
  logic [63:0] m_pend_pc;

  pc_gen #(
    .XLEN       (XLEN),
    .NUM_REDIR  (NUM_REDIR),
    .RESET_ADDR (64'h8000_0000),
    .EPOCH_W    (EPOCH_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redir_valid_i (redir_valid_i),
    .redir_pc_i    (redir_pc_i),
    .stall_i       (stall_i),
    .rvc_i         (rvc_i),
    .fetch_ready_i (fetch_ready_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_pc_o    (fetch_pc_o),
    .fetch_epoch_o (fetch_epoch_o),
    .redir_taken_o (redir_taken_o),
    .pend_valid_o  (pend_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of one rising edge, written straight from the behavioural rules:
  // the lowest-numbered requester wins, targets lose bit 0, a redirect is
  // either taken now (running, not stalled) or remembered for later.
  task automatic model_edge();
    bit          found;
    logic [63:0] target;
    bit          can_apply;
    found  = 0;
    target = 64'd0;
    for (int k = 0; k < NUM_REDIR; k++) begin
      if (!found && redir_valid_i[k]) begin
        found  = 1;
        target = redir_pc_i[k*XLEN +: XLEN];
      end
    end
    target = target & ~64'd1;
    if (rst) begin
      m_run     = 0;
      m_pc      = 64'h8000_0000;
      m_epoch   = 0;
      m_taken   = 0;
      m_pend_v  = 0;
      m_pend_pc = 64'd0;
      return;
    end
    can_apply = m_run && !stall_i;
    m_taken   = 0;
    if (can_apply && (found || m_pend_v)) begin
      m_pc     = found ? target : m_pend_pc;
      m_epoch  = (m_epoch + 1) % (1 << EPOCH_W);
      m_taken  = 1;
      m_pend_v = 0;
    end else if (can_apply && fetch_ready_i) begin
      m_pc = m_pc + (rvc_i ? 64'd2 : 64'd4);
    end else if (!can_apply && found) begin
      m_pend_v  = 1;
      m_pend_pc = target;
    end
    m_run = 1;
  endtask

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    redir_valid_i = '0;
    redir_pc_i    = '0;
    stall_i       = 1'b0;
    rvc_i         = 1'b0;
    fetch_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_redir(input int k, input logic [63:0] target);
    redir_valid_i[k]            = 1'b1;
    redir_pc_i[k*XLEN +: XLEN]  = target;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    set_redir(0, 64'h1234);
    set_redir(2, 64'h5678);
    tick();
    tick();
    vectors += 5;
    if (fetch_pc_o !== 64'h8000_0000) begin
      miscompares++; $display("[TB] FAIL reset_pc: got %h expected %h", fetch_pc_o, 64'h8000_0000);
    end
    if (fetch_epoch_o !== 3'd0) begin
      miscompares++; $display("[TB] FAIL reset_epoch: got %0d expected 0", fetch_epoch_o);
    end
    if (fetch_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", fetch_valid_o);
    end
    if (redir_taken_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_taken: got %b expected 0", redir_taken_o);
    end
    if (pend_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_pend: got %b expected 0", pend_valid_o);
    end
    clear_inputs();
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc [3];
    exp_pc[0] = 64'h8000_0000;
    exp_pc[1] = 64'h8000_0004;
    exp_pc[2] = 64'h8000_0008;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors += 2;
      if (fetch_pc_o !== exp_pc[i]) begin
        miscompares++; $display("[TB] FAIL seq_pc[%0d]: got %h expected %h", i, fetch_pc_o, exp_pc[i]);
      end
      if (fetch_valid_o !== 1'b1) begin
        miscompares++; $display("[TB] FAIL seq_valid[%0d]: got %b expected 1", i, fetch_valid_o);
      end
    end
  endtask

  task automatic test_rvc();
    do_reset();
    tick();
    tick();
    vectors++;
    if (fetch_pc_o !== 64'h8000_0004) begin
      miscompares++; $display("[TB] FAIL rvc_start: got %h expected %h", fetch_pc_o, 64'h8000_0004);
    end
    rvc_i = 1'b1;
    tick();
    vectors++;
    if (fetch_pc_o !== 64'h8000_0006) begin
      miscompares++; $display("[TB] FAIL rvc_step2: got %h expected %h", fetch_pc_o, 64'h8000_0006);
    end
    rvc_i = 1'b0;
    tick();
    vectors++;
    if (fetch_pc_o !== 64'h8000_000A) begin
      miscompares++; $display("[TB] FAIL rvc_step4: got %h expected %h", fetch_pc_o, 64'h8000_000A);
    end
  endtask

  task automatic test_redirect_priority();
    int e0;
    e0 = m_epoch;
    set_redir(1, 64'h100);
    set_redir(3, 64'h200);
    tick();
    vectors += 3;
    if (fetch_pc_o !== 64'h100) begin
      miscompares++; $display("[TB] FAIL prio_pc: got %h expected %h", fetch_pc_o, 64'h100);
    end
    if (fetch_epoch_o !== 3'((e0 + 1) % 8)) begin
      miscompares++; $display("[TB] FAIL prio_epoch: got %0d expected %0d", fetch_epoch_o, (e0 + 1) % 8);
    end
    if (redir_taken_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL prio_taken: got %b expected 1", redir_taken_o);
    end
    clear_inputs();
    tick();
    vectors += 2;
    if (redir_taken_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL prio_pulse_end: got %b expected 0", redir_taken_o);
    end
    if (fetch_pc_o !== 64'h104) begin
      miscompares++; $display("[TB] FAIL prio_next: got %h expected %h", fetch_pc_o, 64'h104);
    end
  endtask

  task automatic test_stall_pending();
    logic [63:0] held_pc;
    int          e0;
    held_pc = m_pc;
    e0      = m_epoch;
    stall_i = 1'b1;
    set_redir(0, 64'h301);
    for (int i = 0; i < 3; i++) begin
      tick();
      redir_valid_i = '0;
      vectors += 3;
      if (pend_valid_o !== 1'b1) begin
        miscompares++; $display("[TB] FAIL stall_pend[%0d]: got %b expected 1", i, pend_valid_o);
      end
      if (fetch_pc_o !== held_pc) begin
        miscompares++; $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, fetch_pc_o, held_pc);
      end
      if (redir_taken_o !== 1'b0) begin
        miscompares++; $display("[TB] FAIL stall_taken[%0d]: got %b expected 0", i, redir_taken_o);
      end
    end
    stall_i = 1'b0;
    tick();
    vectors += 3;
    if (fetch_pc_o !== 64'h300) begin
      miscompares++; $display("[TB] FAIL pend_apply_pc: got %h expected %h", fetch_pc_o, 64'h300);
    end
    if (pend_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL pend_clear: got %b expected 0", pend_valid_o);
    end
    if (fetch_epoch_o !== 3'((e0 + 1) % 8)) begin
      miscompares++; $display("[TB] FAIL pend_epoch: got %0d expected %0d", fetch_epoch_o, (e0 + 1) % 8);
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (fetch_pc_o !== 64'h8000_0010) begin
      miscompares++; $display("[TB] FAIL abort_start: got %h expected %h", fetch_pc_o, 64'h8000_0010);
    end
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (fetch_pc_o !== 64'h8000_0010) begin
        miscompares++; $display("[TB] FAIL abort_stable[%0d]: got %h expected %h", i, fetch_pc_o, 64'h8000_0010);
      end
    end
    set_redir(2, 64'h400);
    tick();
    vectors += 2;
    if (fetch_pc_o !== 64'h400) begin
      miscompares++; $display("[TB] FAIL abort_pc: got %h expected %h", fetch_pc_o, 64'h400);
    end
    if (fetch_epoch_o !== 3'd1) begin
      miscompares++; $display("[TB] FAIL abort_epoch: got %0d expected 1", fetch_epoch_o);
    end
    clear_inputs();
  endtask

  task automatic test_epoch_wrap_and_reset();
    for (int i = 0; i < 8 && m_epoch != 7; i++) begin
      redir_valid_i = '0;
      set_redir(1, 64'h1000 + 64'(i * 16));
      tick();
    end
    vectors++;
    if (fetch_epoch_o !== 3'd7) begin
      miscompares++; $display("[TB] FAIL epoch_at7: got %0d expected 7", fetch_epoch_o);
    end
    set_redir(0, 64'h2000);
    tick();
    vectors++;
    if (fetch_epoch_o !== 3'd0) begin
      miscompares++; $display("[TB] FAIL epoch_wrap: got %0d expected 0", fetch_epoch_o);
    end
    stall_i = 1'b1;
    set_redir(0, 64'h3000);
    tick();
    vectors++;
    if (pend_valid_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rst_pend_setup: got %b expected 1", pend_valid_o);
    end
    stall_i = 1'b0;
    rst     = 1'b1;
    tick();
    vectors += 5;
    if (fetch_pc_o !== 64'h8000_0000) begin
      miscompares++; $display("[TB] FAIL rst_pend_pc: got %h expected %h", fetch_pc_o, 64'h8000_0000);
    end
    if (fetch_epoch_o !== 3'd0) begin
      miscompares++; $display("[TB] FAIL rst_pend_epoch: got %0d expected 0", fetch_epoch_o);
    end
    if (fetch_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_pend_valid: got %b expected 0", fetch_valid_o);
    end
    if (redir_taken_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_pend_taken: got %b expected 0", redir_taken_o);
    end
    if (pend_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_pend_clear: got %b expected 0", pend_valid_o);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 39) == 0);
      stall_i       = ($urandom_range(0, 3) == 0);
      rvc_i         = $urandom_range(0, 1) == 1;
      fetch_ready_i = ($urandom_range(0, 3) != 0);
      redir_valid_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      for (int k = 0; k < NUM_REDIR; k++)
        redir_pc_i[k*XLEN +: XLEN] = {$urandom, $urandom};
      tick();
      vectors += 5;
      if (fetch_pc_o !== m_pc) begin
        miscompares++; $display("[TB] FAIL rand_pc[%0d]: got %h expected %h", c, fetch_pc_o, m_pc);
      end
      if (fetch_epoch_o !== 3'(m_epoch)) begin
        miscompares++; $display("[TB] FAIL rand_epoch[%0d]: got %0d expected %0d", c, fetch_epoch_o, m_epoch);
      end
      if (fetch_valid_o !== m_run) begin
        miscompares++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", c, fetch_valid_o, m_run);
      end
      if (redir_taken_o !== m_taken) begin
        miscompares++; $display("[TB] FAIL rand_taken[%0d]: got %b expected %b", c, redir_taken_o, m_taken);
      end
      if (pend_valid_o !== m_pend_v) begin
        miscompares++; $display("[TB] FAIL rand_pend[%0d]: got %b expected %b", c, pend_valid_o, m_pend_v);
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  // Scenario sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    clear_inputs();
    m_run = 0; m_pc = 64'h8000_0000; m_epoch = 0; m_taken = 0;
    m_pend_v = 0; m_pend_pc = 64'd0;
    #2;
    test_reset();
    test_sequential();
    test_rvc();
    test_redirect_priority();
    test_stall_pending();
    test_abort();
    test_epoch_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
